// File: rtl/iiitb_sipo_if.sv
// iiitb_sipo_if: parallel word output bus with valid/ready handshake
interface iiitb_sipo_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  modport master(output data_out, out_valid, input out_ready);
  modport slave(input data_out, out_valid, output out_ready);
endinterface

// File: rtl/iiitb_sipo.sv
// iiitb_sipo: serial-in parallel-out deserializer with holding register, valid/ready output and sticky errors
module iiitb_sipo #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_en,
  input  logic         start,
  input  logic         serial_in,
  input  logic         err_clr,
  iiitb_sipo_if.master out_bus,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST = LSB_FIRST ? '0 : LAST;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [CW-1:0]    cnt_q, cnt_d, idx;
  logic             valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d, done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q & ~out_bus.out_ready;
    ovr_d   = ovr_q & ~err_clr;
    ferr_d  = ferr_q & ~err_clr;
    done    = 1'b0;
    idx     = LSB_FIRST ? cnt_q : LAST - cnt_q;
    word    = shift_q;
    word[idx] = serial_in;
    if (bit_en && start) begin
      // a start always opens a fresh word; mid-word it also drops the partial one
      shift_d        = '0;
      shift_d[FIRST] = serial_in;
      cnt_d          = CW'(1);
      state_d        = SHIFT;
      ferr_d         = (state_q == SHIFT) | ferr_d;
    end else if (bit_en && state_q == SHIFT) begin
      shift_d = word;
      done    = (cnt_q == LAST);
      cnt_d   = done ? '0 : cnt_q + CW'(1);
      state_d = done ? IDLE : SHIFT;
    end
    // holding register is free when empty or being drained this cycle
    if (done && (!valid_q || out_bus.out_ready)) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end
  end
  assign out_bus.data_out  = data_q;
  assign out_bus.out_valid = valid_q;
  assign busy              = (state_q == SHIFT);
  assign overrun           = ovr_q;
  assign frame_err         = ferr_q;
endmodule

// File: tb/tb_iiitb_sipo.sv
// tb_iiitb_sipo: random and directed checks of both bit orders against a bit-queue reference model
module tb_iiitb_sipo;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, bit_en = 1'b0, start = 1'b0, serial_in = 1'b0;
  logic err_clr = 1'b0, out_ready = 1'b0;
  logic busy_l, ovr_l, ferr_l, busy_m, ovr_m, ferr_m;
  int tests = 0, fails = 0;
  bit m_in, m_valid, m_ovr, m_ferr;
  bit q[$];
  logic [W-1:0] m_data_l, m_data_m;
  always #5 clk = ~clk;
  iiitb_sipo_if #(.WIDTH(W)) bl();
  iiitb_sipo_if #(.WIDTH(W)) bm();
  assign bl.out_ready = out_ready;
  assign bm.out_ready = out_ready;
  iiitb_sipo #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .start(start), .serial_in(serial_in),
    .err_clr(err_clr), .out_bus(bl), .busy(busy_l), .overrun(ovr_l), .frame_err(ferr_l));
  iiitb_sipo #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .start(start), .serial_in(serial_in),
    .err_clr(err_clr), .out_bus(bm), .busy(busy_m), .overrun(ovr_m), .frame_err(ferr_m));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("busy_l", busy_l, m_in);
    check("busy_m", busy_m, m_in);
    check("valid_l", bl.out_valid, m_valid);
    check("valid_m", bm.out_valid, m_valid);
    check("data_l", bl.data_out, m_data_l);
    check("data_m", bm.data_out, m_data_m);
    check("ovr_l", ovr_l, m_ovr);
    check("ovr_m", ovr_m, m_ovr);
    check("ferr_l", ferr_l, m_ferr);
    check("ferr_m", ferr_m, m_ferr);
  endtask
  task automatic model_reset();
    m_in = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
    q.delete();
    m_data_l = '0; m_data_m = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic cycle(input bit en, input bit st, input bit sin, input bit rdy, input bit clr);
    bit done, ev_ferr, ev_ovr;
    logic [W-1:0] wl, wm;
    bit_en = en; start = st; serial_in = sin; out_ready = rdy; err_clr = clr;
    @(posedge clk);
    done = 0; ev_ferr = 0; ev_ovr = 0; wl = '0; wm = '0;
    if (en && st) begin
      ev_ferr = m_in;
      q.delete();
      q.push_back(sin);
      m_in = 1;
    end else if (en && m_in) begin
      q.push_back(sin);
      if (q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wl[i] = q[i];
          wm[W-1-i] = q[i];
        end
        done = 1; m_in = 0;
        q.delete();
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_data_l = wl; m_data_m = wm; m_valid = 1;
    end else begin
      ev_ovr = done;
      if (m_valid && rdy) m_valid = 0;
    end
    m_ovr  = (m_ovr && !clr) || ev_ovr;
    m_ferr = (m_ferr && !clr) || ev_ferr;
    #1;
    check_all();
  endtask
  task automatic send_word(input logic [W-1:0] w, input bit rdy_rest, input bit rdy_last);
    for (int i = 0; i < W; i++) cycle(1, i == 0, w[i], (i == W - 1) ? rdy_last : rdy_rest, 0);
  endtask
  initial begin
    do_reset();
    send_word(4'b1101, 0, 0);
    check("t1_valid", bl.out_valid, 1);
    check("t1_data", bl.data_out, 4'hD);
    check("t1_data_m", bm.data_out, 4'hB);
    cycle(0, 0, 0, 1, 0);
    check("t1_clear", bl.out_valid, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("gap_busy", busy_l, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    check("gap_data", bl.data_out, 4'hD);
    check("gap_ferr", ferr_l, 0);
    cycle(0, 0, 0, 1, 0);
    send_word(4'h3, 0, 0);
    send_word(4'hA, 0, 0);
    check("ovr_data", bl.data_out, 4'h3);
    check("ovr_flag", ovr_l, 1);
    cycle(0, 0, 0, 0, 1);
    check("ovr_clr", ovr_l, 0);
    send_word(4'h6, 0, 1);
    check("refill_valid", bl.out_valid, 1);
    check("refill_data", bl.data_out, 4'h6);
    check("refill_ovr", ovr_l, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    send_word(4'hA, 0, 0);
    check("frame_err", ferr_l, 1);
    check("frame_data", bl.data_out, 4'hA);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 1, 0, 1);
    cycle(1, 1, 0, 0, 1);
    check("clr_vs_event", ferr_l, 1);
    cycle(1, 0, 1, 0, 0);
    do_reset();
    check("rst_busy", busy_l, 0);
    send_word(4'h5, 0, 0);
    check("post_rst_data", bl.data_out, 4'h5);
    send_word(4'b0001, 1, 1);
    check("msb_first", bm.data_out, 4'b1000);
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(9) < 7, $urandom_range(9) < 2, 1'($urandom), 1'($urandom),
            $urandom_range(19) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iiitb_sipo.md
Name: iiitb_sipo

Overview:
- Serial-in parallel-out deserializer. It is the receive end of the team's PISO serial link.
- It accepts an LSB-first bit stream, one bit per enabled clock, framed by a start strobe on the first bit.
- It reassembles WIDTH-bit words into a holding register and presents them on a valid/ready handshake to the downstream parallel consumer.
- It flags framing and overrun errors.

Parameters:
- WIDTH, 4, word length in bits (min 2).
- LSB_FIRST, 1, 1 = first received bit lands in data_out[0]; 0 = first bit lands in data_out[WIDTH-1].

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- bit_en  input  1  qualifies serial_in/start this cycle. When low, nothing is sampled.
- start  input  1  with bit_en, marks serial_in as bit 0 of a new word.
- serial_in  input  1  serial data bit.
- data_out  output  WIDTH  assembled word (holding register).
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts data_out when out_valid & out_ready.
- busy  output  1  a word is partially received.
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- frame_err  output  1  sticky: start arrived mid-word.
- err_clr  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (async, rst_n low): state=IDLE, shift register=0, bit count=0, data_out=0, out_valid=0, busy=0, overrun=0, frame_err=0. Reset mid-word discards the partial word with no error.
- A sample occurs only on cycles with bit_en=1. bit_en=0 freezes the shift register and count.
- FSM states: IDLE and SHIFT.
- IDLE:
  - A sample with start=1 stores serial_in as bit 0, sets count=1 and moves to SHIFT (busy=1 from the next cycle).
  - A sample with start=0 is ignored and the block stays in IDLE.
- SHIFT:
  - Each sample with start=0 stores serial_in at bit index count, then count++.
  - Bit placement: index count when LSB_FIRST=1; index WIDTH-1-count when LSB_FIRST=0.
  - On the sample that stores index WIDTH-1 (count==WIDTH-1), the word is complete. The FSM returns to IDLE and count goes to 0.
- Start mid-word: a sample in SHIFT with start=1 sets frame_err=1 and discards the partial word. serial_in is taken as bit 0 of a new word, count=1, and the FSM stays in SHIFT.
- Word completion and the holding register:
  - If the holding register is free, the completed word is written to data_out and out_valid=1 on the next cycle. Latency is 1 clock after the final bit's sampling edge.
  - The register is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (accept and refill simultaneously, so out_valid stays 1 with the new word).
  - Otherwise the new word is dropped, data_out is unchanged and overrun=1.
- Handshake:
  - out_valid & out_ready with no completion in the same cycle clears out_valid next cycle. data_out keeps its last value.
  - data_out is stable while out_valid=1 and unaccepted.
  - out_ready with out_valid=0 has no effect.
- busy=1 exactly while the FSM is in SHIFT.
- err_clr clears both sticky flags. If an error event occurs in the same cycle as err_clr, the event wins and the flag is set.
- Back-to-back words are supported: start on the sample right after a completing sample begins the next word with no gap cycle.

Test Plan:
- Single word, WIDTH=4, LSB_FIRST=1: bit_en=1 every cycle, start on the first bit, serial bits 1,0,1,1 -> data_out=4'b1101 (0xD), out_valid=1 one clock after the 4th sampling edge. out_ready=1 then clears out_valid next cycle.
- bit_en gaps: same 1,0,1,1 stream with bit_en low for 2 cycles between bits 1 and 2 -> data_out=0xD, busy held high during the gap, no error flags.
- Overrun: receive 0x3 and leave out_ready=0, then receive 0xA -> data_out stays 0x3, overrun=1. err_clr pulse -> overrun=0.
- Simultaneous accept and refill: out_valid=1 with 0x3; the final bit of 0x6 arrives while out_ready=1 -> out_valid stays 1, data_out=0x6, overrun=0.
- Frame error and reset: start, bits 1,1, then start again followed by bits 0,1,0,1 -> frame_err=1, data_out=0xA. Separately, assert rst_n=0 after 2 bits of a word -> all outputs 0, and the next full word decodes correctly.
- LSB_FIRST=0 build: bits 1,0,0,0 -> data_out=4'b1000.
